// File: rtl/run_det_pkg.sv
// Shared definitions for the run-length detector.
// Default NUM_STATES/CNT_W values, a counter width type and the one-hot
// helper used to build the Moore state-indicator vector.
package run_det_pkg;

    localparam int NUM_STATES_DEF = 3;
    localparam int CNT_W_DEF      = 8;
    localparam int MAX_STATES     = 16;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // One-hot of idx within an n-wide field.
    // If idx is at or above n, no bit is set, so unreachable
    // encodings decode to an all-zero Y.
    function automatic logic [MAX_STATES-1:0] onehot_of(input logic [31:0] idx,
                                                        input int unsigned n);
        logic [MAX_STATES-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_STATES; i++) begin
            if ((i == idx) && (idx < n))
                v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr has priority over inc. The count holds at all ones instead of
// wrapping. sat is registered and tracks the value being loaded
// into q on the same edge.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q,
    output logic             sat
);

    logic [CNT_W-1:0] r_q;
    logic             r_sat;
    logic [CNT_W-1:0] w_next;

    // Next count: clear first, then a non-wrapping increment.
    always_comb begin
        w_next = r_q;
        if (clr)
            w_next = '0;
        else if (inc && !(&r_q))
            w_next = r_q + 1'b1;
    end

    // Count and saturation-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else begin
            r_q   <= w_next;
            r_sat <= &w_next;
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule

// File: rtl/run_detector.sv
// Run-length detector on a serial bit stream.
// The state index counts consecutive ones and saturates at
// NUM_STATES-1, which is the threshold state. Y is the one-hot
// Moore indicator of the state. Z2 flags that a qualifying run is
// continuing, and Z1 flags that a qualifying run has just ended.
// run_cnt counts Z1 events, saturating, and is cleared by clr.
// Optional macro RUN_DET_REG_MEALY_EN registers Z1/Z2 (one-cycle
// delay, glitch-free). run_cnt still uses the raw term.
module run_detector
    import run_det_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  X,
    input  logic                  clr,
    output logic [NUM_STATES-1:0] Y,
    output logic                  Z1,
    output logic                  Z2,
    output logic [CNT_W-1:0]      run_cnt,
    output logic                  cnt_sat
);

    localparam int              ST_W = ($clog2(NUM_STATES) < 1) ? 1 : $clog2(NUM_STATES);
    localparam logic [ST_W-1:0] LAST = ST_W'(NUM_STATES - 1);

    logic [ST_W-1:0]       r_ps;
    logic [ST_W-1:0]       w_ns;
    logic [MAX_STATES-1:0] w_oh;
    logic                  w_z1;
    logic                  w_z2;

    // Present-state register. An asynchronous reset returns to state 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ps <= '0;
        else
            r_ps <= w_ns;
    end

    // Next state: a one advances toward the threshold and then holds there.
    // A zero, or any unreachable encoding, returns to state 0.
    always_comb begin
        w_ns = '0;
        if (X && (r_ps < LAST))
            w_ns = r_ps + 1'b1;
        else if (X && (r_ps == LAST))
            w_ns = LAST;
    end

    // Output decode: Y depends only on the state.
    // The Z terms also use X in the same cycle.
    always_comb begin
        w_oh = onehot_of({{(32-ST_W){1'b0}}, r_ps}, NUM_STATES);
        Y    = w_oh[NUM_STATES-1:0];
        w_z1 = (r_ps == LAST) & ~X;
        w_z2 = (r_ps == LAST) &  X;
    end

`ifdef RUN_DET_REG_MEALY_EN
    logic r_z1;
    logic r_z2;

    // Register the Mealy terms so that glitches on X cannot reach the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_z1 <= 1'b0;
            r_z2 <= 1'b0;
        end else begin
            r_z1 <= w_z1;
            r_z2 <= w_z2;
        end
    end

    assign Z1 = r_z1;
    assign Z2 = r_z2;
`else
    assign Z1 = w_z1;
    assign Z2 = w_z2;
`endif

    // Completed-run counter, driven by the unregistered Z1 term.
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_z1),
        .clr   (clr),
        .q     (run_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector.
// The model tracks the current run length of ones, capped at NS-1,
// and the number of completed qualifying runs. A negedge compare
// process checks every output on every cycle. Directed literal
// checks pin the model to hand-computed values.
module tb_run_detector;

`ifdef RUN_DET_REG_MEALY_EN
    localparam int NS = 4;
`else
    localparam int NS = 3;
`endif
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          X;
    logic          clr;
    logic [NS-1:0] Y;
    logic          Z1;
    logic          Z2;
    logic [CW-1:0] run_cnt;
    logic          cnt_sat;

    int n_chk = 0;
    int n_err = 0;

    run_detector #(.NUM_STATES(NS), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .X       (X),
        .clr     (clr),
        .Y       (Y),
        .Z1      (Z1),
        .Z2      (Z2),
        .run_cnt (run_cnt),
        .cnt_sat (cnt_sat)
    );

    always #5 clk = ~clk;

    // Model state: current run length of ones and the completed-run count.
    int m_run = 0;
    int m_cnt = 0;
    bit m_z1q = 1'b0;
    bit m_z2q = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run <= 0;
            m_cnt <= 0;
            m_z1q <= 1'b0;
            m_z2q <= 1'b0;
        end else begin
            m_z1q <= (m_run == NS-1) && (X == 1'b0);
            m_z2q <= (m_run == NS-1) && (X == 1'b1);
            m_cnt <= clr ? 0 : (((m_run == NS-1) && (X == 1'b0) && (m_cnt < CMAX)) ? m_cnt + 1 : m_cnt);
            m_run <= (X == 1'b1) ? ((m_run + 1 > NS-1) ? NS-1 : m_run + 1) : 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every cycle.
    always @(negedge clk) begin
        chk("Y",       32'(Y),       32'(1) << m_run);
`ifdef RUN_DET_REG_MEALY_EN
        chk("Z1",      32'(Z1),      32'(m_z1q));
        chk("Z2",      32'(Z2),      32'(m_z2q));
`else
        chk("Z1",      32'((m_run == NS-1) && (X == 1'b0)) ^ 32'(Z1), 32'(0));
        chk("Z2",      32'((m_run == NS-1) && (X == 1'b1)) ^ 32'(Z2), 32'(0));
`endif
        chk("run_cnt", 32'(run_cnt), 32'(m_cnt));
        chk("cnt_sat", 32'(cnt_sat), 32'(m_cnt == CMAX));
    end

    // Drive X/clr just after a rising edge, then let the outputs settle.
    task automatic step(input logic x, input logic c);
        @(posedge clk);
        #1;
        X   = x;
        clr = c;
        #1;
    endtask

    // One qualifying run: NS-1 ones, then a zero that ends it.
    // The extra idle step makes the count update visible.
    task automatic run_once();
        repeat (NS-1) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        X     = 1'b0;
        clr   = 1'b0;

        // Reset held while X toggles.
        for (int i = 0; i < 4; i++) step(logic'(i % 2), 1'b0);
        chk("rst_Y",   32'(Y),       32'(1));
        chk("rst_Z",   32'({Z1, Z2}), 32'(0));
        chk("rst_cnt", 32'(run_cnt), 32'(0));
        @(posedge clk);
        #1;
        X     = 1'b0;
        reset = 1'b1;
        step(1'b0, 1'b0);
        chk("rel_Y", 32'(Y), 32'(1));

        // Progression: NS ones, then a zero.
        step(1'b1, 1'b0);
        chk("p1_Y", 32'(Y), 32'(1));
        for (int k = 1; k < NS; k++) begin
            step(1'b1, 1'b0);
            chk("pk_Y", 32'(Y), 32'(1) << k);
        end
`ifdef RUN_DET_REG_MEALY_EN
        chk("p_Z2reg0", 32'(Z2), 32'(0));
        step(1'b0, 1'b0);
        chk("p_Z2reg1", 32'(Z2), 32'(1));
        chk("p_Z1reg0", 32'(Z1), 32'(0));
        chk("p_cnt0",   32'(run_cnt), 32'(0));
        step(1'b0, 1'b0);
        chk("p_Z1reg1", 32'(Z1), 32'(1));
        chk("p_cnt1",   32'(run_cnt), 32'(1));
        chk("p_Yend",   32'(Y), 32'(1));
`else
        chk("p_Z2", 32'(Z2), 32'(1));
        step(1'b0, 1'b0);
        chk("p_Z1",   32'(Z1), 32'(1));
        chk("p_Y2",   32'(Y), 32'(4));
        chk("p_cnt0", 32'(run_cnt), 32'(0));
        step(1'b0, 1'b0);
        chk("p_cnt1", 32'(run_cnt), 32'(1));
        chk("p_Yend", 32'(Y), 32'(1));
        chk("p_Z1lo", 32'(Z1), 32'(0));
`endif

        // Short runs never reach the threshold.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("s_Y1", 32'(Y), 32'(2));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("s_Y2", 32'(Y), 32'(2));
        step(1'b0, 1'b0);
        chk("s_cnt", 32'(run_cnt), 32'(0));

        // Saturation at 3 with CW=2.
        for (int r = 1; r <= 5; r++) begin
            run_once();
            chk("sat_cnt", 32'(run_cnt), 32'((r > 3) ? 3 : r));
            chk("sat_flg", 32'(cnt_sat), 32'(r >= 3));
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("clr_cnt", 32'(run_cnt), 32'(0));
        chk("clr_sat", 32'(cnt_sat), 32'(0));

        // clr on the same edge as Z1: the event is lost.
        repeat (NS-1) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("clrz1_cnt", 32'(run_cnt), 32'(0));

        // Asynchronous reset pulse while in the threshold state.
        repeat (NS) step(1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_Y",   32'(Y),       32'(1));
        chk("arst_cnt", 32'(run_cnt), 32'(0));
        #1;
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("arst_cnt2", 32'(run_cnt), 32'(0));

        // Mixed pattern to exercise the model further.
        for (int i = 0; i < 20; i++) step(logic'((32'hB7D5 >> i) & 1), 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
